// File: rtl/wb_param_veriyolu.sv
// wb_param_veriyolu
// -----------------
// Bridges the core's data-bus request port (vy_*) to N_KOLE Wishbone classic
// slaves. Each request is decoded against a table of base addresses; the
// lowest-indexed matching slave gets the bus cycle. An address that matches no
// slave ends the transaction at once with a bus error. The response path is
// registered: vy_veri_o / vy_hata_o are valid in the single DONE (TAMAM) cycle.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   vy_adres_i            request byte address
//   vy_veri_i             write data
//   vy_veri_maske_i       byte enables (nonzero = write, zero = read)
//   vy_sec_i              request valid, held stable while stalled
//   vy_veri_o             read data, held until the next DONE
//   vy_durdur_o           stall to the core
//   vy_hata_o             bus error, valid in the DONE cycle only
//   wb_adr_o, wb_dat_o    registered low address bits / write data
//   wb_we_o, wb_sel_o     write enable / byte select (4'hF on reads)
//   wb_stb_o, wb_cyc_o    strobe / one-hot cycle per slave
//   wb_ack_i, wb_dat_i    per-slave ack / per-slave read data
//
// Configuration
//   WB_ZAMAN_ASIMI_EN     when defined, a bus cycle that sees no ack for
//                         ZAMAN_ASIMI cycles is abandoned with vy_hata_o=1.
//                         When undefined the bridge waits for ack forever.

module wb_param_veriyolu #(
    parameter int                    N_KOLE      = 3,
    parameter logic [32*N_KOLE-1:0]  TABAN_ADR   = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [31:0]           ADR_MASKE   = 32'hFFFF_FF00,
    parameter int                    ADR_W       = 8,
    parameter int                    ZAMAN_ASIMI = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            vy_adres_i,
    input  logic [31:0]            vy_veri_i,
    input  logic [3:0]             vy_veri_maske_i,
    input  logic                   vy_sec_i,
    output logic [31:0]            vy_veri_o,
    output logic                   vy_durdur_o,
    output logic                   vy_hata_o,
    output logic [ADR_W-1:0]       wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic                   wb_stb_o,
    output logic [N_KOLE-1:0]      wb_cyc_o,
    input  logic [N_KOLE-1:0]      wb_ack_i,
    input  logic [32*N_KOLE-1:0]   wb_dat_i
);

    localparam int IDX_W = (N_KOLE > 1) ? $clog2(N_KOLE) : 1;

    typedef enum logic [1:0] {
        BOSTA,
        ISTEK,
        TAMAM
    } durum_t;

    durum_t             durum;
    logic [IDX_W-1:0]   secili_idx;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [N_KOLE-1:0]  hit_onehot;
    logic               secili_ack;
    logic [31:0]        secili_veri;
    logic               zaman_doldu;

    // Address decode; scanning upward and stopping at the first match makes
    // the lowest index win when regions overlap.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = 0; i < N_KOLE; i++) begin
            if (!hit && ((vy_adres_i & ADR_MASKE) == TABAN_ADR[32*i +: 32])) begin
                hit           = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // wb_cyc_o is one-hot on the selected slave for the whole bus cycle, so
    // masking the acks with it discards acks from every other slave.
    assign secili_ack = |(wb_ack_i & wb_cyc_o);

    always_comb begin
        secili_veri = '0;
        for (int i = 0; i < N_KOLE; i++) begin
            if (IDX_W'(i) == secili_idx) begin
                secili_veri = wb_dat_i[32*i +: 32];
            end
        end
    end

`ifdef WB_ZAMAN_ASIMI_EN
    localparam int                SAY_W   = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SAY_W-1:0]  SAY_SON = SAY_W'(ZAMAN_ASIMI - 1);

    logic [SAY_W-1:0] sayac;

    // Counts completed ISTEK cycles; it sits at zero outside ISTEK so it is
    // already cleared when a new bus cycle begins.
    always_ff @(posedge clk_i) begin
        if (rst_i || (durum != ISTEK)) begin
            sayac <= '0;
        end else begin
            sayac <= sayac + 1'b1;
        end
    end

    assign zaman_doldu = (sayac == SAY_SON);
`else
    assign zaman_doldu = 1'b0;
`endif

    assign vy_durdur_o = vy_sec_i & (durum != TAMAM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum      <= BOSTA;
            secili_idx <= '0;
            wb_cyc_o   <= '0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            vy_veri_o  <= '0;
            vy_hata_o  <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (vy_sec_i) begin
                        if (hit) begin
                            wb_cyc_o   <= hit_onehot;
                            wb_stb_o   <= 1'b1;
                            wb_adr_o   <= vy_adres_i[ADR_W-1:0];
                            wb_dat_o   <= vy_veri_i;
                            wb_we_o    <= |vy_veri_maske_i;
                            wb_sel_o   <= (vy_veri_maske_i == 4'h0) ? 4'hF : vy_veri_maske_i;
                            secili_idx <= hit_idx;
                            durum      <= ISTEK;
                        end else begin
                            // Decode miss: no bus cycle at all.
                            vy_hata_o <= 1'b1;
                            vy_veri_o <= '0;
                            durum     <= TAMAM;
                        end
                    end
                end
                ISTEK: begin
                    if (secili_ack) begin
                        wb_cyc_o  <= '0;
                        wb_stb_o  <= 1'b0;
                        // A write keeps the last read result on vy_veri_o.
                        if (!wb_we_o) begin
                            vy_veri_o <= secili_veri;
                        end
                        vy_hata_o <= 1'b0;
                        durum     <= TAMAM;
                    end else if (zaman_doldu) begin
                        wb_cyc_o  <= '0;
                        wb_stb_o  <= 1'b0;
                        vy_hata_o <= 1'b1;
                        vy_veri_o <= '0;
                        durum     <= TAMAM;
                    end
                end
                TAMAM: begin
                    vy_hata_o <= 1'b0;
                    durum     <= BOSTA;
                end
                default: begin
                    durum <= BOSTA;
                end
            endcase
        end
    end

endmodule
